// File: rtl/slave_if_reg.sv
// slave_if_reg: registered crossbar-to-slave bridge holding one transaction until ack or timeout
module slave_if_reg #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_from_crossbar,
  input  logic [ADDR_W-1:0] addr_from_crossbar,
  input  logic [DATA_W-1:0] wdata_from_crossbar,
  input  logic              cmd_from_crossbar,
  input  logic              connect_approved_from_crossbar,
  output logic              ack_to_crossbar,
  output logic [DATA_W-1:0] rdata_to_crossbar,
  output logic              err_to_crossbar,
  output logic              busy_to_crossbar,
  output logic              req_to_slave,
  output logic [ADDR_W-1:0] addr_to_slave,
  output logic [DATA_W-1:0] wdata_to_slave,
  output logic              cmd_to_slave,
  input  logic              ack_from_slave,
  input  logic [DATA_W-1:0] rdata_from_slave
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [TMO_W-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic cmd_q, cmd_d, err_q, err_d;
  logic accept, tmo;
  assign accept = req_from_crossbar && connect_approved_from_crossbar;
  assign tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
  // next-state: capture in IDLE, wait for ack or timeout in REQ, single response cycle in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = REQ;
        cnt_d   = '0;
        addr_d  = addr_from_crossbar;
        cmd_d   = cmd_from_crossbar;
        wdata_d = cmd_from_crossbar ? wdata_from_crossbar : '0;
      end
      REQ: if (ack_from_slave) begin
        state_d = RESP;
        rdata_d = cmd_q ? '0 : rdata_from_slave;
        err_d   = 1'b0;
      end else if (tmo) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cmd_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_to_slave      = state_q == REQ;
  assign addr_to_slave     = req_to_slave ? addr_q : '0;
  assign wdata_to_slave    = req_to_slave ? wdata_q : '0;
  assign cmd_to_slave      = req_to_slave && cmd_q;
  assign ack_to_crossbar   = state_q == RESP;
  assign rdata_to_crossbar = ack_to_crossbar ? rdata_q : '0;
  assign err_to_crossbar   = ack_to_crossbar && err_q;
  assign busy_to_crossbar  = state_q != IDLE;
endmodule

// File: tb/tb_slave_if_reg.sv
// tb_slave_if_reg: randomized transaction-level check of slave_if_reg against a duration model
module tb_slave_if_reg;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_from_crossbar = 1'b0;
  logic [31:0] addr_from_crossbar = '0;
  logic [31:0] wdata_from_crossbar = '0;
  logic cmd_from_crossbar = 1'b0;
  logic connect_approved_from_crossbar = 1'b0;
  logic ack_to_crossbar;
  logic [31:0] rdata_to_crossbar;
  logic err_to_crossbar;
  logic busy_to_crossbar;
  logic req_to_slave;
  logic [31:0] addr_to_slave;
  logic [31:0] wdata_to_slave;
  logic cmd_to_slave;
  logic ack_from_slave = 1'b0;
  logic [31:0] rdata_from_slave = '0;
  int checks = 0;
  int errors = 0;
  slave_if_reg #(.ADDR_W(32), .DATA_W(32), .TMO_W(8), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req_from_crossbar(req_from_crossbar),
    .addr_from_crossbar(addr_from_crossbar),
    .wdata_from_crossbar(wdata_from_crossbar),
    .cmd_from_crossbar(cmd_from_crossbar),
    .connect_approved_from_crossbar(connect_approved_from_crossbar),
    .ack_to_crossbar(ack_to_crossbar),
    .rdata_to_crossbar(rdata_to_crossbar),
    .err_to_crossbar(err_to_crossbar),
    .busy_to_crossbar(busy_to_crossbar),
    .req_to_slave(req_to_slave),
    .addr_to_slave(addr_to_slave),
    .wdata_to_slave(wdata_to_slave),
    .cmd_to_slave(cmd_to_slave),
    .ack_from_slave(ack_from_slave),
    .rdata_from_slave(rdata_from_slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, " req_to_slave"}, req_to_slave, 0);
    chk({tag, " addr_to_slave"}, addr_to_slave, 0);
    chk({tag, " wdata_to_slave"}, wdata_to_slave, 0);
    chk({tag, " cmd_to_slave"}, cmd_to_slave, 0);
    chk({tag, " ack"}, ack_to_crossbar, 0);
    chk({tag, " rdata"}, rdata_to_crossbar, 0);
    chk({tag, " err"}, err_to_crossbar, 0);
    chk({tag, " busy"}, busy_to_crossbar, 0);
  endtask
  // One transaction: slave acks after w REQ cycles (w=0: ack in first REQ cycle).
  // Model: the slave sees min(w+1, TO) request cycles; ack wins unless w >= TO.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic c,
                     input int w, input logic [31:0] rd, input bit hold);
    int n;
    bit to;
    logic [31:0] exp_wd, exp_rd;
    to = w >= TO;
    n = to ? TO : w + 1;
    exp_wd = c ? wd : 32'h0;
    exp_rd = (to || c) ? 32'h0 : rd;
    req_from_crossbar = 1'b1;
    connect_approved_from_crossbar = 1'b1;
    addr_from_crossbar = a;
    wdata_from_crossbar = wd;
    cmd_from_crossbar = c;
    ack_from_slave = 1'b0;
    cyc;
    for (int k = 0; k < n; k++) begin
      chk("req_to_slave", req_to_slave, 1);
      chk("addr_to_slave", addr_to_slave, a);
      chk("wdata_to_slave", wdata_to_slave, exp_wd);
      chk("cmd_to_slave", cmd_to_slave, c);
      chk("busy in req", busy_to_crossbar, 1);
      chk("ack in req", ack_to_crossbar, 0);
      req_from_crossbar = hold ? 1'b1 : 1'($urandom);
      connect_approved_from_crossbar = hold ? 1'b1 : 1'($urandom);
      addr_from_crossbar = $urandom;
      wdata_from_crossbar = $urandom;
      cmd_from_crossbar = 1'($urandom);
      ack_from_slave = k == w;
      rdata_from_slave = (k == w) ? rd : $urandom;
      cyc;
    end
    chk("resp ack", ack_to_crossbar, 1);
    chk("resp rdata", rdata_to_crossbar, exp_rd);
    chk("resp err", err_to_crossbar, to);
    chk("resp req_to_slave", req_to_slave, 0);
    chk("resp addr_to_slave", addr_to_slave, 0);
    chk("resp busy", busy_to_crossbar, 1);
    req_from_crossbar = hold;
    connect_approved_from_crossbar = hold;
    ack_from_slave = 1'($urandom);
    rdata_from_slave = $urandom;
    cyc;
    idle_outputs("post-resp idle");
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end
  initial begin
    #2;
    idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc;
    idle_outputs("after reset");
    txn(32'h100, 32'h0, 1'b0, 2, 32'hDEADBEEF, 1'b0);
    txn(32'h20, 32'h12345678, 1'b1, 0, 32'hFFFFFFFF, 1'b0);
    req_from_crossbar = 1'b1;
    connect_approved_from_crossbar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ack_from_slave = 1'($urandom);
      cyc;
      idle_outputs("no grant");
    end
    txn(32'h44, 32'h0, 1'b0, 20, 32'hCAFEF00D, 1'b0);
    req_from_crossbar = 1'b0;
    ack_from_slave = 1'b1;
    cyc;
    idle_outputs("late ack");
    txn(32'h48, 32'h0, 1'b0, TO - 1, 32'hA5A5A5A5, 1'b0);
    for (int i = 0; i < 5; i++) txn($urandom, $urandom, 1'($urandom), $urandom_range(0, 5), $urandom, 1'b1);
    req_from_crossbar = 1'b1;
    connect_approved_from_crossbar = 1'b1;
    addr_from_crossbar = 32'h55;
    cmd_from_crossbar = 1'b0;
    ack_from_slave = 1'b0;
    cyc;
    chk("pre-reset req_to_slave", req_to_slave, 1);
    req_from_crossbar = 1'b0;
    #2 rst = 1'b1;
    #1;
    idle_outputs("async reset");
    ack_from_slave = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc;
    idle_outputs("after mid reset");
    txn(32'h300, 32'h0, 1'b0, 1, 32'h0BADC0DE, 1'b0);
    for (int i = 0; i < 40; i++) txn($urandom, $urandom, 1'($urandom), $urandom_range(0, 6), $urandom, 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
